// File: rtl/trolley_system_mem_pkg.sv
// Shared types for the trolley on-chip RAM: controller state encoding.
package trolley_system_mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/trolley_system_ram_core.sv
// Single-port byte-enabled RAM with a registered read port; maps onto block RAM.
module trolley_system_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read-first: a write cycle returns the old word, which the top discards.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (be[b]) begin
                        mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/trolley_system_onchip_ram_pipelined.sv
// Pipelined on-chip RAM slave: zero-fill sequencer, host/clear write mux,
// read-valid pipeline and optional output register around the RAM core.
//   state    | meaning
//   ST_CLEAR | writing zeros to clear_addr, waitrequest held high
//   ST_READY | accepting host reads and writes
module trolley_system_onchip_ram_pipelined
    import trolley_system_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    mem_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
    logic                  waitrequest_q, waitrequest_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  host_cmd, host_wr, host_rd;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [NUM_BYTES-1:0]  ram_be;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        host_cmd = chipselect & ~waitrequest_q & (state_q == ST_READY);
        host_wr  = host_cmd & write;
        host_rd  = host_cmd & read & ~write;

        if (state_q == ST_CLEAR) begin
            ram_we    = clken;
            ram_addr  = clear_addr_q;
            ram_be    = '1;
            ram_wdata = '0;
        end else begin
            ram_we    = clken & host_wr;
            ram_addr  = address;
            ram_be    = byteenable;
            ram_wdata = writedata;
        end
    end

    trolley_system_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (clken),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        clear_addr_d  = clear_addr_q;
        waitrequest_d = waitrequest_q;
        rd_valid_d    = rd_valid_q;
        hold_d        = hold_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;

        if (clken) begin
            rd_valid_d  = host_rd;
            out_valid_d = rd_valid_q;
            if (rd_valid_q) begin
                hold_d     = ram_rdata;
                out_data_d = ram_rdata;
            end

            // clear_addr parks at the last address rather than wrapping.
            if (state_q == ST_CLEAR) begin
                if (clear_addr_q == LAST_ADDR) begin
                    state_d       = ST_READY;
                    waitrequest_d = 1'b0;
                end else begin
                    clear_addr_d = clear_addr_q + ADDR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clear_addr_q  <= '0;
            waitrequest_q <= (CLEAR_ON_RESET != 0);
            rd_valid_q    <= 1'b0;
            hold_q        <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            clear_addr_q  <= clear_addr_d;
            waitrequest_q <= waitrequest_d;
            rd_valid_q    <= rd_valid_d;
            hold_q        <= hold_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    // Without the output stage the RAM word is shown only while it is valid.
    assign waitrequest   = waitrequest_q;
    assign readdatavalid = (OUT_REG != 0) ? out_valid_q : rd_valid_q;
    assign readdata      = (OUT_REG != 0) ? out_data_q
                                          : (rd_valid_q ? ram_rdata : hold_q);

endmodule
